vga_sync_pipeline: RTL and testbench

Downstream stage of the horizontal/vertical pixel counters in the VGA controller. Consumes `H_Count_Value` and `V_Count_Value` every pixel clock, decodes 640x480@60 Hz sync and blanking, issues a pixel-fetch request with the active-area coordinate to the frame source, and re-aligns the returned pixel data with delayed sync and blanking. The output is a registered, glitch-free RGB444 + Hsync/Vsync bundle that drives the VGA pins directly.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_sync_pipeline.sv | 78 +++++++
 tb/tb_vga_sync_pipeline.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz timing constants, shared flag bundle and the count decoder
// used by the VGA sync pipeline.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = 525;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int RGB_W = 4;
  localparam int PIX_W = 3 * RGB_W;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } timing_flags_t;

  // Counts outside the frame decode as blank with sync inactive.
  function automatic timing_flags_t decode_counts(input logic [15:0] h, input logic [15:0] v);
    timing_flags_t f;
    logic          in_range;
    in_range = (h < 16'(H_TOTAL)) && (v < 16'(V_TOTAL));
    f.active = in_range && (h < 16'(H_ACTIVE)) && (v < 16'(V_ACTIVE));
    f.hs     = in_range && (h >= 16'(H_SYNC_START)) && (h <= 16'(H_SYNC_END));
    f.vs     = in_range && (v >= 16'(V_SYNC_START)) && (v <= 16'(V_SYNC_END));
    f.fs     = (h == 16'd0) && (v == 16'd0);
    return f;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that carries timing flags alongside the
// pixel-fetch latency; cleared synchronously by reset.
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vga_sync_pipeline.sv
// Decodes pixel counts into sync/blank, requests pixels from the frame source
// and re-aligns returned data with the delayed timing flags at the pins.
module vga_sync_pipeline
  import vga_timing_pkg::*;
#(
  parameter int PIX_LATENCY     = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic [15:0]      H_Count_Value,
  input  logic [15:0]      V_Count_Value,
  output logic             pix_req,
  output logic [9:0]       pix_addr_x,
  output logic [8:0]       pix_addr_y,
  input  logic [PIX_W-1:0] pix_data,
  output logic             Hsync,
  output logic             Vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] red,
  output logic [RGB_W-1:0] green,
  output logic [RGB_W-1:0] blue,
  output logic             frame_start
);

  timing_flags_t flags_nxt;
  timing_flags_t flags_q;
  timing_flags_t flags_d;
  logic [3:0]    flags_d_bits;

  always_comb flags_nxt = decode_counts(H_Count_Value, V_Count_Value);

  // Stage D: decoded flags plus the fetch request for this count.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      flags_q    <= '0;
      pix_addr_x <= '0;
      pix_addr_y <= '0;
    end else begin
      flags_q    <= flags_nxt;
      pix_addr_x <= flags_nxt.active ? H_Count_Value[9:0] : '0;
      pix_addr_y <= flags_nxt.active ? V_Count_Value[8:0] : '0;
    end
  end

  assign pix_req = flags_q.active;

  // Stage A: flags wait out the source latency so they meet pix_data.
  vga_delay_line #(
    .WIDTH (4),
    .DEPTH (PIX_LATENCY)
  ) u_align (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .din       (flags_q),
    .dout      (flags_d_bits)
  );

  assign flags_d = timing_flags_t'(flags_d_bits);

  // Stage O: every pin is a flop; pix_data is masked outside the active area.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      video_on           <= 1'b0;
      {red, green, blue} <= '0;
      Hsync              <= SYNC_ACTIVE_LOW;
      Vsync              <= SYNC_ACTIVE_LOW;
      frame_start        <= 1'b0;
    end else begin
      video_on           <= flags_d.active;
      {red, green, blue} <= flags_d.active ? pix_data : '0;
      Hsync              <= flags_d.hs ^ SYNC_ACTIVE_LOW;
      Vsync              <= flags_d.vs ^ SYNC_ACTIVE_LOW;
      frame_start        <= flags_d.fs;
    end
  end

endmodule

// File: tb/tb_vga_sync_pipeline.sv
// Directed bench for vga_sync_pipeline: two instances (latency 2 / active-low
// sync and latency 5 / active-high sync) share one count stream.
module tb_vga_sync_pipeline;

  localparam int MAXC = 20000;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic [15:0] h_cnt, v_cnt;
  bit          fm;

  logic        pix_req0, pix_req1;
  logic [9:0]  ax0, ax1;
  logic [8:0]  ay0, ay1;
  logic [11:0] pix_data0, pix_data1;
  logic        hs0, vs0, von0, fs0, hs1, vs1, von1, fs1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;

  int hc [MAXC];
  int vc [MAXC];
  bit rs [MAXC];
  bit fmh [MAXC];
  int cyc;
  int n_assert, n_fail;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_sync_pipeline #(.PIX_LATENCY(2), .SYNC_ACTIVE_LOW(1'b1)) dut0 (
    .clk_25MHz(clk_25MHz), .reset(reset), .H_Count_Value(h_cnt), .V_Count_Value(v_cnt),
    .pix_req(pix_req0), .pix_addr_x(ax0), .pix_addr_y(ay0), .pix_data(pix_data0),
    .Hsync(hs0), .Vsync(vs0), .video_on(von0), .red(r0), .green(g0), .blue(b0),
    .frame_start(fs0));

  vga_sync_pipeline #(.PIX_LATENCY(5), .SYNC_ACTIVE_LOW(1'b0)) dut1 (
    .clk_25MHz(clk_25MHz), .reset(reset), .H_Count_Value(h_cnt), .V_Count_Value(v_cnt),
    .pix_req(pix_req1), .pix_addr_x(ax1), .pix_addr_y(ay1), .pix_data(pix_data1),
    .Hsync(hs1), .Vsync(vs1), .video_on(von1), .red(r1), .green(g1), .blue(b1),
    .frame_start(fs1));

  wire [15:0] o0 = {von0, r0, g0, b0, hs0, vs0, fs0};
  wire [15:0] o1 = {von1, r1, g1, b1, hs1, vs1, fs1};
  wire [19:0] q0 = {pix_req0, ax0, ay0};
  wire [19:0] q1 = {pix_req1, ax1, ay1};

  // Frame source model: answers each request after the fixed latency.
  logic [19:0] s0 [2];
  logic [19:0] s1 [5];
  always @(posedge clk_25MHz) begin
    s0[0] <= q0;
    s0[1] <= s0[0];
    s1[0] <= q1;
    for (int i = 1; i < 5; i++) s1[i] <= s1[i-1];
  end
  assign pix_data0 = fm ? 12'hFFF : (s0[1][19] ? {s0[1][12:9], s0[1][3:0], 4'hA} : 12'hBAD);
  assign pix_data1 = fm ? 12'hFFF : (s1[4][19] ? {s1[4][12:9], s1[4][3:0], 4'hA} : 12'hBAD);

  // Expected pin bundle in cycle c: counts driven lat+2 cycles earlier, unless
  // a reset was sampled anywhere along their path.
  function automatic logic [15:0] model_out(input int lat, input bit low, input int c);
    int k;
    logic [15:0] h, v;
    bit inr, act, hsy, vsy, fsy;
    logic [11:0] rgb;
    k = c - lat - 2;
    if (k < 0) return {1'b0, 12'h000, low, low, 1'b0};
    for (int j = k; j < c; j++) if (rs[j]) return {1'b0, 12'h000, low, low, 1'b0};
    h = 16'(hc[k]);
    v = 16'(vc[k]);
    inr = (h < 800) && (v < 525);
    act = inr && (h < 640) && (v < 480);
    hsy = inr && (h >= 656) && (h <= 751);
    vsy = inr && (v >= 490) && (v <= 491);
    fsy = (h == 0) && (v == 0);
    rgb = act ? (fmh[c-1] ? 12'hFFF : {h[3:0], v[3:0], 4'hA}) : 12'h000;
    return {act, rgb, hsy ^ low, vsy ^ low, fsy};
  endfunction

  function automatic logic [19:0] model_req(input int c);
    logic [15:0] h, v;
    if (c < 1) return 20'h0;
    if (rs[c-1]) return 20'h0;
    h = 16'(hc[c-1]);
    v = 16'(vc[c-1]);
    if ((h < 640) && (v < 480)) return {1'b1, h[9:0], v[8:0]};
    return 20'h0;
  endfunction

  task automatic tick(input int h, input int v, input bit r, input bit f);
    @(posedge clk_25MHz);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    h_cnt = 16'(h); v_cnt = 16'(v); reset = r; fm = f;
    hc[cyc] = h; vc[cyc] = v; rs[cyc] = r; fmh[cyc] = f;
    @(negedge clk_25MHz);
  endtask

  task automatic test_reset();
    int n0, n1;
    for (int i = 1; i < 5; i++) begin
      tick(700, 100, 1'b1, 1'b0);
      n_assert += 2;
      if (o0 !== {1'b0, 12'h000, 1'b1, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL reset_out0 cyc=%0d got=%h exp=%h", cyc, o0, {1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
      end
      if (o1 !== 16'h0000) begin
        n_fail++; $display("FAIL reset_out1 cyc=%0d got=%h exp=0000", cyc, o1);
      end
    end
    n0 = -1; n1 = -1;
    for (int n = 0; n < 20; n++) begin
      tick(700, 100, 1'b0, 1'b0);
      if (n0 < 0 && hs0 === 1'b0) n0 = n;
      if (n1 < 0 && hs1 === 1'b1) n1 = n;
    end
    n_assert += 2;
    if (n0 != 4) begin n_fail++; $display("FAIL release_hsync0 got=%0d exp=4", n0); end
    if (n1 != 7) begin n_fail++; $display("FAIL release_hsync1 got=%0d exp=7", n1); end
  endtask

  task automatic test_sweep();
    int lines [11] = '{0, 1, 2, 479, 480, 489, 490, 491, 492, 524, 525};
    int req0, req1, hl0, hh1, vl0, vh1, f0, f1;
    req0 = 0; req1 = 0; hl0 = 0; hh1 = 0; vl0 = 0; vh1 = 0; f0 = 0; f1 = 0;
    for (int i = 0; i < 10; i++) tick(0, 500, 1'b0, 1'b0);
    for (int li = 0; li < 11 * 800 + 10; li++) begin
      if (li < 11 * 800) tick(li % 800, lines[li / 800], 1'b0, 1'b0);
      else tick(0, 500, 1'b0, 1'b0);
      n_assert += 4;
      if (o0 !== model_out(2, 1'b1, cyc)) begin
        n_fail++; $display("FAIL sweep_out0 cyc=%0d got=%h exp=%h", cyc, o0, model_out(2, 1'b1, cyc));
      end
      if (o1 !== model_out(5, 1'b0, cyc)) begin
        n_fail++; $display("FAIL sweep_out1 cyc=%0d got=%h exp=%h", cyc, o1, model_out(5, 1'b0, cyc));
      end
      if (q0 !== model_req(cyc)) begin
        n_fail++; $display("FAIL sweep_req0 cyc=%0d got=%h exp=%h", cyc, q0, model_req(cyc));
      end
      if (q1 !== model_req(cyc)) begin
        n_fail++; $display("FAIL sweep_req1 cyc=%0d got=%h exp=%h", cyc, q1, model_req(cyc));
      end
      req0 += int'(pix_req0); req1 += int'(pix_req1);
      hl0 += int'(!hs0); hh1 += int'(hs1);
      vl0 += int'(!vs0); vh1 += int'(vs1);
      f0 += int'(fs0); f1 += int'(fs1);
    end
    n_assert += 8;
    if (req0 != 2560) begin n_fail++; $display("FAIL sweep_req_count0 got=%0d exp=2560", req0); end
    if (req1 != 2560) begin n_fail++; $display("FAIL sweep_req_count1 got=%0d exp=2560", req1); end
    if (hl0 != 960) begin n_fail++; $display("FAIL sweep_hsync_cycles0 got=%0d exp=960", hl0); end
    if (hh1 != 960) begin n_fail++; $display("FAIL sweep_hsync_cycles1 got=%0d exp=960", hh1); end
    if (vl0 != 1600) begin n_fail++; $display("FAIL sweep_vsync_cycles0 got=%0d exp=1600", vl0); end
    if (vh1 != 1600) begin n_fail++; $display("FAIL sweep_vsync_cycles1 got=%0d exp=1600", vh1); end
    if (f0 != 1) begin n_fail++; $display("FAIL sweep_frame_start0 got=%0d exp=1", f0); end
    if (f1 != 1) begin n_fail++; $display("FAIL sweep_frame_start1 got=%0d exp=1", f1); end
  endtask

  task automatic test_blanking();
    int bad0, bad1, lit0, lit1;
    bad0 = 0; bad1 = 0; lit0 = 0; lit1 = 0;
    for (int i = 0; i < 10; i++) tick(0, 500, 1'b0, 1'b1);
    for (int li = 0; li < 1610; li++) begin
      if (li < 800) tick(li, 100, 1'b0, 1'b1);
      else if (li < 1600) tick(li - 800, 480, 1'b0, 1'b1);
      else tick(0, 500, 1'b0, 1'b1);
      n_assert += 2;
      if (o0 !== model_out(2, 1'b1, cyc)) begin
        n_fail++; $display("FAIL blank_out0 cyc=%0d got=%h exp=%h", cyc, o0, model_out(2, 1'b1, cyc));
      end
      if (o1 !== model_out(5, 1'b0, cyc)) begin
        n_fail++; $display("FAIL blank_out1 cyc=%0d got=%h exp=%h", cyc, o1, model_out(5, 1'b0, cyc));
      end
      if (!von0 && {r0, g0, b0} != 12'h000) bad0++;
      if (!von1 && {r1, g1, b1} != 12'h000) bad1++;
      if (von0 && {r0, g0, b0} == 12'hFFF) lit0++;
      if (von1 && {r1, g1, b1} == 12'hFFF) lit1++;
    end
    n_assert += 4;
    if (bad0 != 0) begin n_fail++; $display("FAIL blank_rgb0 got=%0d exp=0", bad0); end
    if (bad1 != 0) begin n_fail++; $display("FAIL blank_rgb1 got=%0d exp=0", bad1); end
    if (lit0 != 640) begin n_fail++; $display("FAIL blank_lit0 got=%0d exp=640", lit0); end
    if (lit1 != 640) begin n_fail++; $display("FAIL blank_lit1 got=%0d exp=640", lit1); end
  endtask

  task automatic test_out_of_range();
    int ev0, ev1;
    ev0 = 0; ev1 = 0;
    for (int i = 0; i < 10; i++) tick(0, 500, 1'b0, 1'b0);
    for (int li = 0; li < 830; li++) begin
      if (li < 800) tick(li, 525, 1'b0, 1'b0);
      else if (li < 812) tick(800 + (li - 800) * 5, 10, 1'b0, 1'b0);
      else tick(0, 525, 1'b0, 1'b0);
      n_assert += 2;
      if (o0 !== model_out(2, 1'b1, cyc)) begin
        n_fail++; $display("FAIL oor_out0 cyc=%0d got=%h exp=%h", cyc, o0, model_out(2, 1'b1, cyc));
      end
      if (o1 !== model_out(5, 1'b0, cyc)) begin
        n_fail++; $display("FAIL oor_out1 cyc=%0d got=%h exp=%h", cyc, o1, model_out(5, 1'b0, cyc));
      end
      ev0 += int'(pix_req0) + int'(von0) + int'(!vs0) + int'(!hs0) + int'(fs0);
      ev1 += int'(pix_req1) + int'(von1) + int'(vs1) + int'(hs1) + int'(fs1);
    end
    n_assert += 2;
    if (ev0 != 0) begin n_fail++; $display("FAIL oor_events0 got=%0d exp=0", ev0); end
    if (ev1 != 0) begin n_fail++; $display("FAIL oor_events1 got=%0d exp=0", ev1); end
  endtask

  task automatic test_frame_marker();
    int f0, f1, fc0, fc1, vc0, vc1;
    f0 = 0; f1 = 0; fc0 = -1; fc1 = -1; vc0 = -1; vc1 = -1;
    for (int i = 0; i < 10; i++) tick(0, 500, 1'b0, 1'b0);
    for (int li = 0; li < 50; li++) begin
      if (li < 20) tick(780 + li, 524, 1'b0, 1'b0);
      else tick(li - 20, 0, 1'b0, 1'b0);
      if (fs0) begin f0++; fc0 = cyc; end
      if (fs1) begin f1++; fc1 = cyc; end
      if (vc0 < 0 && von0) vc0 = cyc;
      if (vc1 < 0 && von1) vc1 = cyc;
      if (fs0 === 1'b1) begin
        n_assert++;
        if ({von0, r0, g0, b0} !== 13'h100A) begin
          n_fail++; $display("FAIL fs_pixel0 cyc=%0d got=%h exp=100a", cyc, {von0, r0, g0, b0});
        end
      end
    end
    n_assert += 4;
    if (f0 != 1) begin n_fail++; $display("FAIL fs_count0 got=%0d exp=1", f0); end
    if (f1 != 1) begin n_fail++; $display("FAIL fs_count1 got=%0d exp=1", f1); end
    if (fc0 != vc0 || fc0 < 0) begin n_fail++; $display("FAIL fs_align0 fs_cyc=%0d von_cyc=%0d", fc0, vc0); end
    if (fc1 != vc1 || fc1 < 0) begin n_fail++; $display("FAIL fs_align1 fs_cyc=%0d von_cyc=%0d", fc1, vc1); end
    // Latency-5 instance lags the latency-2 one by exactly 3 cycles.
    n_assert++;
    if (fc1 - fc0 != 3) begin n_fail++; $display("FAIL fs_skew got=%0d exp=3", fc1 - fc0); end
  endtask

  task automatic test_mid_line_reset();
    int x0, x1;
    logic [11:0] p0, p1;
    x0 = -1; x1 = -1; p0 = '0; p1 = '0;
    for (int h = 300; h <= 345; h++) begin
      tick(h, 240, h == 320, 1'b0);
      n_assert += 2;
      if (o0 !== model_out(2, 1'b1, cyc)) begin
        n_fail++; $display("FAIL midrst_out0 cyc=%0d got=%h exp=%h", cyc, o0, model_out(2, 1'b1, cyc));
      end
      if (q0 !== model_req(cyc)) begin
        n_fail++; $display("FAIL midrst_req0 cyc=%0d got=%h exp=%h", cyc, q0, model_req(cyc));
      end
      if (h == 321) begin
        n_assert += 2;
        if (o0 !== {1'b0, 12'h000, 1'b1, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL midrst_inactive0 got=%h exp=%h", o0, {1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        end
        if (o1 !== 16'h0000) begin
          n_fail++; $display("FAIL midrst_inactive1 got=%h exp=0000", o1);
        end
      end
      if (h > 321 && x0 < 0 && von0) begin x0 = h; p0 = {r0, g0, b0}; end
      if (h > 321 && x1 < 0 && von1) begin x1 = h; p1 = {r1, g1, b1}; end
    end
    n_assert += 4;
    if (x0 != 325) begin n_fail++; $display("FAIL midrst_first_h0 got=%0d exp=325", x0); end
    if (x1 != 328) begin n_fail++; $display("FAIL midrst_first_h1 got=%0d exp=328", x1); end
    if (p0 !== 12'h10A) begin n_fail++; $display("FAIL midrst_first_pix0 got=%h exp=10a", p0); end
    if (p1 !== 12'h10A) begin n_fail++; $display("FAIL midrst_first_pix1 got=%h exp=10a", p1); end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; h_cnt = 16'd700; v_cnt = 16'd100; fm = 1'b0;
    hc[0] = 700; vc[0] = 100; rs[0] = 1'b1; fmh[0] = 1'b0;
    test_reset();
    test_sweep();
    test_blanking();
    test_out_of_range();
    test_frame_marker();
    test_mid_line_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
